id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  Decode-to-execute pipeline register; sits directly downstream of the register file.
//  Captures SrcData1/SrcData2 plus decoded fields and control, and detects load-use hazards.
//  On a load-use hazard it inserts a bubble and stalls upstream stages.
//  While held, it refreshes latched operands from the writeback port so held data never goes stale.
// PARAMETERS
//  DATA_W    16  operand/immediate/PC width
//  REG_ID_W  4   register specifier width
//  CTRL_W    8   opaque EX/MEM/WB control bundle width, passed through unchanged
// PORTS
//  clk           in   1         rising-edge clock
//  rst           in   1         asynchronous active-low reset (0 = reset)
//  stall_in      in   1         downstream hold request; freeze all state
//  flush         in   1         squash; next state is a bubble
//  id_valid      in   1         decode slot holds a real instruction
//  id_pc         in   DATA_W    PC of the decode instruction
//  id_rs, id_rt  in   REG_ID_W  source specifiers (SrcReg1/SrcReg2)
//  id_uses_rs/rt in   1         each source is actually read
//  id_rd         in   REG_ID_W  destination specifier
//  id_src1/2     in   DATA_W    register-file read data (already WB-bypassed)
//  id_imm        in   DATA_W    sign/zero-extended immediate
//  id_mem_read   in   1         instruction is a load
//  id_reg_write  in   1         instruction writes rd
//  id_ctrl       in   CTRL_W    remaining control bits
//  wb_write      in   1         register-file write this cycle (WriteReg)
//  wb_rd         in   REG_ID_W  write destination (DstReg)
//  wb_data       in   DATA_W    write data (DstData)
//  hazard_stall  out  1         combinational; holds PC and IF/ID
//  ex_valid, ex_pc, ex_rs, ex_rt, ex_rd, ex_src1, ex_src2, ex_imm,
//  ex_mem_read, ex_reg_write, ex_ctrl   out   registered copies of id_* fields
// BEHAVIOUR
//  - Reset (rst=0, async): every ex_* output is 0, ex_valid=0; counters 0. hazard_stall=0 follows.
//  - hazard_stall = ex_valid & ex_mem_read & id_valid & ex_rd!=0 &
//    ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
//  - Next-state priority at each posedge:
//    1 flush: bubble, i.e. ex_valid=0, ex_mem_read=0, ex_reg_write=0, ex_ctrl=0; other fields don't-care (hold).
//    2 stall_in: hold all fields, except operand refresh (below).
//    3 hazard_stall: bubble (as flush); upstream holds, so the instruction re-presents next cycle.
//    4 otherwise: capture all id_* fields; ex_valid=id_valid. id_valid=0 forces the bubble control values.
//  - Latency: one cycle from id_* to ex_*. A load-use pair costs exactly one bubble.
//  - Operand refresh, applied only in case 2 with ex_valid=1 and wb_write=1 and wb_rd!=0:
//    ex_src1<=wb_data if wb_rd==ex_rs; ex_src2<=wb_data if wb_rd==ex_rt. Both may update together.
//  - Register 0 never matches, for either the hazard or the refresh.
//  - flush with stall_in: flush wins. flush with hazard_stall: bubble, and hazard_stall still asserts that cycle.
//  - Reset mid-stall: state clears immediately, with no wait for a clock edge.
// CONFIGURATION
//  ID_EX_PERF_CNT_EN defined: adds outputs perf_bubbles[15:0] and perf_stalls[15:0].
//    perf_bubbles increments on each case-3 cycle; perf_stalls increments on each case-2 cycle.
//    Both saturate at 16'hFFFF and reset to 0.
//  Not defined: counters and ports absent; the rest of the behaviour is identical.
// TESTING
//  1 Reset: drive rst=0 mid-run with ex_valid=1 -> all ex_* =0 at once; hazard_stall=0.
//  2 Capture: id_valid=1, id_src1=16'h1234, id_rd=4'd5 -> next cycle ex_src1=16'h1234, ex_rd=5, ex_valid=1.
//  3 Load-use: EX holds load with rd=3; ID id_rs=3, id_uses_rs=1 -> hazard_stall=1, next ex_valid=0;
//    next cycle hazard_stall=0 and the instruction is captured. Same case with rd=0 -> no stall.
//  4 Refresh: stall_in=1 with ex_rs=7, ex_rt=7; wb_write=1, wb_rd=7, wb_data=16'hBEEF -> ex_src1=ex_src2=16'hBEEF, other fields held.
//  5 Flush priority: flush=1 and stall_in=1 together -> next ex_valid=0, ex_reg_write=0, ex_mem_read=0.
//  6 Counters (ID_EX_PERF_CNT_EN): 3 hazard bubbles + 2 stall cycles -> perf_bubbles=3, perf_stalls=2;
//    preload perf_stalls to 16'hFFFF, one more stall cycle -> stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with load-use hazard detection, bubble insertion and
// writeback refresh of held operands. Optional performance counters: define ID_EX_PERF_CNT_EN.
module id_ex_pipe_reg #(
    parameter int DATA_W   = 16,
    parameter int REG_ID_W = 4,
    parameter int CTRL_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_in,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [DATA_W-1:0]   id_pc,
    input  logic [REG_ID_W-1:0] id_rs,
    input  logic [REG_ID_W-1:0] id_rt,
    input  logic                id_uses_rs,
    input  logic                id_uses_rt,
    input  logic [REG_ID_W-1:0] id_rd,
    input  logic [DATA_W-1:0]   id_src1,
    input  logic [DATA_W-1:0]   id_src2,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic                id_mem_read,
    input  logic                id_reg_write,
    input  logic [CTRL_W-1:0]   id_ctrl,
    input  logic                wb_write,
    input  logic [REG_ID_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                hazard_stall,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_pc,
    output logic [REG_ID_W-1:0] ex_rs,
    output logic [REG_ID_W-1:0] ex_rt,
    output logic [REG_ID_W-1:0] ex_rd,
    output logic [DATA_W-1:0]   ex_src1,
    output logic [DATA_W-1:0]   ex_src2,
    output logic [DATA_W-1:0]   ex_imm,
    output logic                ex_mem_read,
    output logic                ex_reg_write,
    output logic [CTRL_W-1:0]   ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [15:0]         perf_bubbles,
    output logic [15:0]         perf_stalls
`endif
);

    logic                valid_q,     valid_d;
    logic [DATA_W-1:0]   pc_q,        pc_d;
    logic [REG_ID_W-1:0] rs_q,        rs_d;
    logic [REG_ID_W-1:0] rt_q,        rt_d;
    logic [REG_ID_W-1:0] rd_q,        rd_d;
    logic [DATA_W-1:0]   imm_q,       imm_d;
    logic                mem_read_q,  mem_read_d;
    logic                reg_write_q, reg_write_d;
    logic [CTRL_W-1:0]   ctrl_q,      ctrl_d;
    logic [DATA_W-1:0]   src_q [2];
    logic [DATA_W-1:0]   src_d [2];

    logic [DATA_W-1:0]   id_src    [2];
    logic [REG_ID_W-1:0] src_id_q  [2];
    logic [1:0]          refresh_hit;

    logic rs_hit, rt_hit;
    logic take_stall, take_bubble, take_capture;
    logic wb_live;

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign rs_hit = id_uses_rs && (rd_q == id_rs);
    assign rt_hit = id_uses_rt && (rd_q == id_rt);
    assign hazard_stall = valid_q && mem_read_q && id_valid &&
                          (rd_q != '0) && (rs_hit || rt_hit);

    assign take_stall   = !flush && stall_in;
    assign take_bubble  = !flush && !stall_in && hazard_stall;
    assign take_capture = !flush && !stall_in && !hazard_stall;

    assign wb_live = take_stall && valid_q && wb_write && (wb_rd != '0);

    assign id_src[0]   = id_src1;
    assign id_src[1]   = id_src2;
    assign src_id_q[0] = rs_q;
    assign src_id_q[1] = rt_q;

    // Each held operand independently tracks writes to its own source register.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign refresh_hit[gi] = wb_live && (wb_rd == src_id_q[gi]);
            assign src_d[gi] = take_capture     ? id_src[gi] :
                               refresh_hit[gi]  ? wb_data    :
                                                  src_q[gi];
        end
    endgenerate

    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        mem_read_d  = mem_read_q;
        reg_write_d = reg_write_q;
        ctrl_d      = ctrl_q;
        if (flush || take_bubble) begin
            valid_d     = 1'b0;
            mem_read_d  = 1'b0;
            reg_write_d = 1'b0;
            ctrl_d      = '0;
        end else if (take_capture) begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            rs_d        = id_rs;
            rt_d        = id_rt;
            rd_d        = id_rd;
            imm_d       = id_imm;
            mem_read_d  = id_mem_read;
            reg_write_d = id_reg_write;
            ctrl_d      = id_ctrl;
            // An empty decode slot must not leak side-effecting control downstream.
            if (!id_valid) begin
                mem_read_d  = 1'b0;
                reg_write_d = 1'b0;
                ctrl_d      = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            mem_read_q  <= 1'b0;
            reg_write_q <= 1'b0;
            ctrl_q      <= '0;
            src_q[0]    <= '0;
            src_q[1]    <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            mem_read_q  <= mem_read_d;
            reg_write_q <= reg_write_d;
            ctrl_q      <= ctrl_d;
            src_q[0]    <= src_d[0];
            src_q[1]    <= src_d[1];
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign ex_src1      = src_q[0];
    assign ex_src2      = src_q[1];
    assign ex_imm       = imm_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_reg_write = reg_write_q;
    assign ex_ctrl      = ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] bubbles_q, bubbles_d;
    logic [15:0] stalls_q,  stalls_d;

    always_comb begin
        bubbles_d = bubbles_q;
        stalls_d  = stalls_q;
        if (take_bubble && (bubbles_q != 16'hFFFF)) begin
            bubbles_d = bubbles_q + 16'd1;
        end
        if (take_stall && (stalls_q != 16'hFFFF)) begin
            stalls_d = stalls_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubbles_q <= '0;
            stalls_q  <= '0;
        end else begin
            bubbles_q <= bubbles_d;
            stalls_q  <= stalls_d;
        end
    end

    assign perf_bubbles = bubbles_q;
    assign perf_stalls  = stalls_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomised self-checking bench for id_ex_pipe_reg against a transaction-level reference model.
// Counter checks are compiled in only when ID_EX_PERF_CNT_EN is defined.
module tb_id_ex_pipe_reg;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic [15:0] src1;
        logic [15:0] src2;
        logic [15:0] imm;
        logic        mem_read;
        logic        reg_write;
        logic [7:0]  ctrl;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in, flush, id_valid;
    logic [15:0] id_pc, id_src1, id_src2, id_imm, wb_data;
    logic [3:0]  id_rs, id_rt, id_rd, wb_rd;
    logic        id_uses_rs, id_uses_rt, id_mem_read, id_reg_write, wb_write;
    logic [7:0]  id_ctrl;
    logic        hazard_stall, ex_valid, ex_mem_read, ex_reg_write;
    logic [15:0] ex_pc, ex_src1, ex_src2, ex_imm;
    logic [3:0]  ex_rs, ex_rt, ex_rd;
    logic [7:0]  ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] perf_bubbles, perf_stalls;
    int          exp_bubbles, exp_stalls;
`endif

    ex_t m;
    ex_t dut_vec;
    int  n_vec = 0;
    int  n_err = 0;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_src1(id_src1), .id_src2(id_src2), .id_imm(id_imm),
        .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_ctrl(id_ctrl),
        .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_src1(ex_src1),
        .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .ex_ctrl(ex_ctrl)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    assign dut_vec = {ex_valid, ex_pc, ex_rs, ex_rt, ex_rd, ex_src1, ex_src2,
                      ex_imm, ex_mem_read, ex_reg_write, ex_ctrl};

    // A load in EX blocks any decode instruction that actually reads its (non-zero) target.
    function automatic logic model_hazard();
        logic dep;
        dep = (id_uses_rs && id_rs == m.rd) || (id_uses_rt && id_rt == m.rd);
        return m.valid && m.mem_read && id_valid && (m.rd != 4'd0) && dep;
    endfunction

    function automatic ex_t model_next();
        ex_t n;
        ex_t bubble;
        n = m;
        bubble = m;
        bubble.valid = 1'b0;
        bubble.mem_read = 1'b0;
        bubble.reg_write = 1'b0;
        bubble.ctrl = 8'h00;
        if (flush) begin
            n = bubble;
        end else if (stall_in) begin
            if (m.valid && wb_write && wb_rd != 4'd0) begin
                if (wb_rd == m.rs) n.src1 = wb_data;
                if (wb_rd == m.rt) n.src2 = wb_data;
            end
        end else if (model_hazard()) begin
            n = bubble;
        end else begin
            n = '{valid: id_valid, pc: id_pc, rs: id_rs, rt: id_rt, rd: id_rd,
                  src1: id_src1, src2: id_src2, imm: id_imm,
                  mem_read: id_valid && id_mem_read,
                  reg_write: id_valid && id_reg_write,
                  ctrl: id_valid ? id_ctrl : 8'h00};
        end
        return n;
    endfunction

    task automatic tick();
        ex_t nxt;
        nxt = model_next();
`ifdef ID_EX_PERF_CNT_EN
        if (!flush && stall_in) exp_stalls = (exp_stalls < 65535) ? exp_stalls + 1 : 65535;
        else if (!flush && model_hazard()) exp_bubbles = (exp_bubbles < 65535) ? exp_bubbles + 1 : 65535;
`endif
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic idle();
        stall_in = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_rd = 0; id_src1 = 0; id_src2 = 0;
        id_imm = 0; id_mem_read = 0; id_reg_write = 0; id_ctrl = 0;
        wb_write = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic rand_inputs();
        id_valid     = ($urandom_range(0, 3) != 0);
        id_pc        = 16'($urandom);
        id_rs        = 4'($urandom_range(0, 3));
        id_rt        = 4'($urandom_range(0, 3));
        id_rd        = 4'($urandom_range(0, 3));
        id_uses_rs   = 1'($urandom_range(0, 1));
        id_uses_rt   = 1'($urandom_range(0, 1));
        id_src1      = 16'($urandom);
        id_src2      = 16'($urandom);
        id_imm       = 16'($urandom);
        id_mem_read  = ($urandom_range(0, 2) == 0);
        id_reg_write = 1'($urandom_range(0, 1));
        id_ctrl      = 8'($urandom);
        flush        = ($urandom_range(0, 9) == 0);
        stall_in     = ($urandom_range(0, 4) == 0);
        wb_write     = 1'($urandom_range(0, 1));
        wb_rd        = 4'($urandom_range(0, 3));
        wb_data      = 16'($urandom);
    endtask

    task automatic do_reset_now();
        rst = 1'b0;
        m = '0;
`ifdef ID_EX_PERF_CNT_EN
        exp_bubbles = 0;
        exp_stalls  = 0;
`endif
    endtask

    task automatic test_reset();
        idle();
        do_reset_now();
        #22 rst = 1'b1;
        n_vec++;
        if (dut_vec !== 87'd0) begin
            n_err++; $display("FAIL reset_initial: got %h want 0", dut_vec);
        end
        @(posedge clk); #1;
        id_valid = 1; id_pc = 16'h0100; id_rd = 4'd9; id_reg_write = 1; id_src1 = 16'h5555;
        tick();
        n_vec++;
        if (ex_valid !== 1'b1) begin
            n_err++; $display("FAIL reset_setup_valid: got %b want 1", ex_valid);
        end
        // Assert reset between edges; outputs must clear without a clock.
        #2 do_reset_now();
        #1;
        n_vec++;
        if (dut_vec !== 87'd0 || hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL reset_async: got %h hz %b want 0", dut_vec, hazard_stall);
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        $display("test_reset: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_capture();
        idle();
        id_valid = 1; id_src1 = 16'h1234; id_rd = 4'd5; id_pc = 16'h0200;
        id_imm = 16'hFFF0; id_reg_write = 1; id_ctrl = 8'hA5;
        tick();
        n_vec++;
        if (ex_src1 !== 16'h1234 || ex_rd !== 4'd5 || ex_valid !== 1'b1) begin
            n_err++; $display("FAIL capture: src1=%h rd=%0d v=%b want 1234 5 1", ex_src1, ex_rd, ex_valid);
        end
        n_vec++;
        if (dut_vec !== m) begin
            n_err++; $display("FAIL capture_all: got %h want %h", dut_vec, m);
        end
        idle();
        id_valid = 0; id_reg_write = 1; id_mem_read = 1; id_ctrl = 8'hFF; id_pc = 16'h0300;
        tick();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_ctrl !== 8'h00 || ex_pc !== 16'h0300) begin
            n_err++; $display("FAIL capture_invalid: got %h want bubble with pc 0300", dut_vec);
        end
        $display("test_capture: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_load_use();
        idle();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 4'd3;
        tick();
        idle();
        id_valid = 1; id_rs = 4'd3; id_uses_rs = 1; id_rd = 4'd6; id_src1 = 16'hAAAA; id_reg_write = 1;
        #1;
        n_vec++;
        if (hazard_stall !== 1'b1) begin
            n_err++; $display("FAIL loaduse_detect: got %b want 1", hazard_stall);
        end
        tick();
        n_vec++;
        if (ex_valid !== 1'b0 || hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL loaduse_bubble: v=%b hz=%b want 0 0", ex_valid, hazard_stall);
        end
        tick();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_src1 !== 16'hAAAA || ex_rd !== 4'd6) begin
            n_err++; $display("FAIL loaduse_capture: v=%b src1=%h rd=%0d want 1 AAAA 6", ex_valid, ex_src1, ex_rd);
        end
        idle();
        id_valid = 1; id_mem_read = 1; id_rd = 4'd0;
        tick();
        idle();
        id_valid = 1; id_rs = 4'd0; id_rt = 4'd0; id_uses_rs = 1; id_uses_rt = 1; id_pc = 16'h0444;
        #1;
        n_vec++;
        if (hazard_stall !== 1'b0) begin
            n_err++; $display("FAIL loaduse_r0: got %b want 0", hazard_stall);
        end
        tick();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_pc !== 16'h0444) begin
            n_err++; $display("FAIL loaduse_r0_capture: v=%b pc=%h want 1 0444", ex_valid, ex_pc);
        end
        $display("test_load_use: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_refresh();
        idle();
        id_valid = 1; id_rs = 4'd7; id_rt = 4'd7; id_uses_rs = 1; id_uses_rt = 1;
        id_rd = 4'd2; id_src1 = 16'h1111; id_src2 = 16'h2222; id_pc = 16'h0040; id_reg_write = 1;
        tick();
        rand_inputs();
        flush = 0; stall_in = 1; wb_write = 1; wb_rd = 4'd7; wb_data = 16'hBEEF;
        tick();
        n_vec++;
        if (ex_src1 !== 16'hBEEF || ex_src2 !== 16'hBEEF || ex_pc !== 16'h0040 || ex_rd !== 4'd2 || ex_valid !== 1'b1) begin
            n_err++; $display("FAIL refresh: got %h want src1=src2=BEEF pc 0040 rd 2", dut_vec);
        end
        wb_rd = 4'd5; wb_data = 16'h0BAD;
        tick();
        n_vec++;
        if (ex_src1 !== 16'hBEEF || ex_src2 !== 16'hBEEF) begin
            n_err++; $display("FAIL refresh_nomatch: src1=%h src2=%h want BEEF BEEF", ex_src1, ex_src2);
        end
        $display("test_refresh: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_flush();
        idle();
        id_valid = 1; id_reg_write = 1; id_mem_read = 1; id_rd = 4'd4; id_ctrl = 8'h3C;
        tick();
        idle();
        id_valid = 1; id_rs = 4'd4; id_uses_rs = 1; flush = 1;
        #1;
        n_vec++;
        if (hazard_stall !== 1'b1) begin
            n_err++; $display("FAIL flush_hazard_asserts: got %b want 1", hazard_stall);
        end
        stall_in = 1;
        tick();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_ctrl !== 8'h00) begin
            n_err++; $display("FAIL flush_priority: got %h want bubble", dut_vec);
        end
        $display("test_flush: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_back_to_back();
        logic [15:0] prev_pc;
        idle();
        for (int i = 0; i < 8; i++) begin
            id_valid = 1; id_pc = 16'(16'h1000 + i * 4); id_rd = 4'(i + 1); id_reg_write = 1;
            prev_pc = id_pc;
            tick();
            n_vec++;
            if (ex_pc !== prev_pc || ex_valid !== 1'b1) begin
                n_err++; $display("FAIL b2b_%0d: pc=%h v=%b want %h 1", i, ex_pc, ex_valid, prev_pc);
            end
        end
        $display("test_back_to_back: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            #1;
            n_vec++;
            if (hazard_stall !== model_hazard()) begin
                n_err++; $display("FAIL rand_hazard_%0d: got %b want %b", i, hazard_stall, model_hazard());
            end
            tick();
            n_vec++;
            if (dut_vec !== m) begin
                n_err++; $display("FAIL rand_state_%0d: got %h want %h", i, dut_vec, m);
            end
`ifdef ID_EX_PERF_CNT_EN
            n_vec++;
            if (perf_bubbles !== 16'(exp_bubbles) || perf_stalls !== 16'(exp_stalls)) begin
                n_err++; $display("FAIL rand_perf_%0d: got %0d %0d want %0d %0d", i, perf_bubbles, perf_stalls, exp_bubbles, exp_stalls);
            end
`endif
        end
        $display("test_random: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

`ifdef ID_EX_PERF_CNT_EN
    task automatic test_counters();
        idle();
        #2 do_reset_now();
        #2 rst = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) begin
            idle();
            id_valid = 1; id_mem_read = 1; id_rd = 4'd3;
            tick();
            idle();
            id_valid = 1; id_rt = 4'd3; id_uses_rt = 1;
            tick();
        end
        idle();
        stall_in = 1;
        tick();
        tick();
        n_vec++;
        if (perf_bubbles !== 16'd3 || perf_stalls !== 16'd2) begin
            n_err++; $display("FAIL perf_count: got %0d %0d want 3 2", perf_bubbles, perf_stalls);
        end
        for (int i = 0; i < 65533; i++) tick();
        n_vec++;
        if (perf_stalls !== 16'hFFFF) begin
            n_err++; $display("FAIL perf_reach_max: got %h want FFFF", perf_stalls);
        end
        tick();
        n_vec++;
        if (perf_stalls !== 16'hFFFF || perf_bubbles !== 16'd3) begin
            n_err++; $display("FAIL perf_saturate: got %h %0d want FFFF 3", perf_stalls, perf_bubbles);
        end
        idle();
        $display("test_counters: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask
`endif

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_refresh();
        test_flush();
        test_back_to_back();
        test_random();
`ifdef ID_EX_PERF_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
